// File: rtl/ndro_pulse_driver_if.sv
// Command/response handshake between a sequencer and the NDRO pulse driver.
interface ndro_pulse_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_data;
    logic       rsp_mismatch;

    modport master (
        output cmd_valid, cmd_op,
        input  cmd_ready, rsp_valid, rsp_data, rsp_mismatch
    );

    modport slave (
        input  cmd_valid, cmd_op,
        output cmd_ready, rsp_valid, rsp_data, rsp_mismatch
    );
endinterface

// File: rtl/ndro_pulse_driver.sv
// Edge-encoded SET/RESET/READ driver for one NDRO cell, with hold-spacing guards
// and a synchronised out-toggle read path.
module ndro_pulse_driver #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned READ_WAIT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ndro_pulse_driver_if.slave bus,
    output logic               ndro_set,
    output logic               ndro_reset,
    output logic               ndro_clk,
    input  logic               ndro_out,
    output logic               shadow
);
    localparam int unsigned   CW       = 4;
    localparam logic [CW-1:0] CNT_MAX  = CW'(15);
    localparam logic [CW-1:0] HOLD     = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] RWAIT    = CW'(READ_WAIT);
    localparam logic [1:0]    OP_SET   = 2'b01;
    localparam logic [1:0]    OP_RESET = 2'b10;
    localparam logic [1:0]    OP_READ  = 2'b11;

    typedef enum logic [1:0] {IDLE, GUARD, WAIT_OUT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          out_s;
    logic          guard_set_q, guard_set_d;
    logic [CW-1:0] since_rst_q, since_rst_d;
    logic [CW-1:0] since_clk_q, since_clk_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          set_q, set_d, reset_q, reset_d, nclk_q, nclk_d;
    logic          shadow_q, shadow_d, out_prev_q, out_prev_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_data_q, rsp_data_d, rsp_mis_q, rsp_mis_d;
    logic          set_ok, reset_ok, fire_set, fire_reset;

    // Two-flop synchroniser for the asynchronous cell output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], ndro_out};
    end
    assign out_s = sync_q[1];

    // Counters hold the edge distance since the last toggle, so the guards are simple compares.
    assign set_ok   = (since_rst_q >= HOLD);
    assign reset_ok = (since_clk_q >= HOLD);

    always_comb begin
        state_d     = state_q;
        guard_set_d = guard_set_q;
        wait_d      = wait_q;
        since_rst_d = (since_rst_q == CNT_MAX) ? since_rst_q : since_rst_q + CW'(1);
        since_clk_d = (since_clk_q == CNT_MAX) ? since_clk_q : since_clk_q + CW'(1);
        set_d       = set_q;
        reset_d     = reset_q;
        nclk_d      = nclk_q;
        shadow_d    = shadow_q;
        out_prev_d  = out_prev_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_mis_d   = rsp_mis_q;
        fire_set    = 1'b0;
        fire_reset  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_SET: begin
                            if (set_ok) fire_set = 1'b1;
                            else begin
                                guard_set_d = 1'b1;
                                state_d     = GUARD;
                            end
                        end
                        OP_RESET: begin
                            if (reset_ok) fire_reset = 1'b1;
                            else begin
                                guard_set_d = 1'b0;
                                state_d     = GUARD;
                            end
                        end
                        OP_READ: begin
                            nclk_d      = ~nclk_q;
                            since_clk_d = CW'(1);
                            out_prev_d  = out_s;
                            wait_d      = CW'(1);
                            state_d     = WAIT_OUT;
                        end
                        default: ;
                    endcase
                end
            end
            GUARD: begin
                if (guard_set_q && set_ok) begin
                    fire_set = 1'b1;
                    state_d  = IDLE;
                end else if (!guard_set_q && reset_ok) begin
                    fire_reset = 1'b1;
                    state_d    = IDLE;
                end
            end
            WAIT_OUT: begin
                if (wait_q == RWAIT) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = out_s ^ out_prev_q;
                    rsp_mis_d   = (out_s ^ out_prev_q) ^ shadow_q;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (fire_set) begin
            set_d    = ~set_q;
            shadow_d = 1'b1;
        end
        if (fire_reset) begin
            reset_d     = ~reset_q;
            shadow_d    = 1'b0;
            since_rst_d = CW'(1);
        end
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            guard_set_q <= 1'b0;
            wait_q      <= '0;
            since_rst_q <= CNT_MAX;
            since_clk_q <= CNT_MAX;
            set_q       <= 1'b0;
            reset_q     <= 1'b0;
            nclk_q      <= 1'b0;
            shadow_q    <= 1'b0;
            out_prev_q  <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            rsp_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_set_q <= guard_set_d;
            wait_q      <= wait_d;
            since_rst_q <= since_rst_d;
            since_clk_q <= since_clk_d;
            set_q       <= set_d;
            reset_q     <= reset_d;
            nclk_q      <= nclk_d;
            shadow_q    <= shadow_d;
            out_prev_q  <= out_prev_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_mis_q   <= rsp_mis_d;
        end
    end

    assign ndro_set         = set_q;
    assign ndro_reset       = reset_q;
    assign ndro_clk         = nclk_q;
    assign shadow           = shadow_q;
    assign bus.cmd_ready    = ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_mismatch = rsp_mis_q;
endmodule

// File: tb/tb_ndro_pulse_driver.sv
// Bench for ndro_pulse_driver: directed vector table, hand-written corner sequences,
// and random commands scored against an edge-index model of the guard/read rules.
`timescale 1ns/1ps
module tb_ndro_pulse_driver;
    localparam int HOLD_A = 2;
    localparam int RW_A   = 4;
    localparam int HOLD_B = 8;
    localparam int RW_B   = 3;
    localparam logic [1:0] OP_NOP = 2'b00, OP_SET = 2'b01, OP_RESET = 2'b10, OP_READ = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    ndro_pulse_driver_if bus_a();
    ndro_pulse_driver_if bus_b();
    logic set_a, reset_a, nclk_a, shadow_a;
    logic set_b, reset_b, nclk_b, shadow_b;
    logic out_a = 1'b0;
    logic out_b = 1'b0;

    ndro_pulse_driver #(.HOLD_CYCLES(HOLD_A), .READ_WAIT(RW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .ndro_set(set_a), .ndro_reset(reset_a),
        .ndro_clk(nclk_a), .ndro_out(out_a), .shadow(shadow_a));
    ndro_pulse_driver #(.HOLD_CYCLES(HOLD_B), .READ_WAIT(RW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .ndro_set(set_b), .ndro_reset(reset_b),
        .ndro_clk(nclk_b), .ndro_out(out_b), .shadow(shadow_b));

    // Behavioural NDRO cell on DUT A: out toggles shortly after a clk pulse while the cell holds 1.
    logic cell_a = 1'b0, stuck_a = 1'b0;
    logic cps = 1'b0, cpr = 1'b0, cpc = 1'b0;
    always @(set_a, reset_a, nclk_a, rst_n) begin
        if (!rst_n) begin
            cell_a = 1'b0;
            out_a <= 1'b0;
        end else begin
            if (set_a != cps) cell_a = 1'b1;
            if (reset_a != cpr) cell_a = 1'b0;
            if (nclk_a != cpc && cell_a && !stuck_a) out_a <= #1 ~out_a;
        end
        cps = set_a; cpr = reset_a; cpc = nclk_a;
    end

    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int e; logic d; logic m; } rsp_t;
    int   exp_set_q[$], exp_rst_q[$], exp_clk_q[$];
    rsp_t exp_rsp_q[$];
    bit   model_on = 1'b0;

    // Monitor: records toggle edges and responses; scores them against the model when enabled.
    logic pset_a = 0, prst_a = 0, pclk_a = 0, prst_b = 0, pclk_b = 0;
    int last_set_a = -1, last_rst_a = -1, last_clk_a = -1, last_rsp_a = -1, rsp_cnt_a = 0;
    int last_rst_b = -1, last_clk_b = -1;
    logic last_d_a = 0, last_m_a = 0;
    always @(posedge clk) begin
        int   ntog;
        rsp_t r;
        #2;
        if (!rst_n) begin
            pset_a = 0; prst_a = 0; pclk_a = 0; prst_b = 0; pclk_b = 0;
        end else begin
            ntog = 0;
            if (set_a != pset_a) begin
                ntog++; last_set_a = edge_cnt;
                if (model_on) begin
                    if (exp_set_q.size() == 0) chk("rnd_unexpected_set", edge_cnt, -1);
                    else chk("rnd_set_edge", edge_cnt, exp_set_q.pop_front());
                    chk("rnd_set_shadow", int'(shadow_a), 1);
                end
            end
            if (reset_a != prst_a) begin
                ntog++; last_rst_a = edge_cnt;
                if (model_on) begin
                    if (exp_rst_q.size() == 0) chk("rnd_unexpected_reset", edge_cnt, -1);
                    else chk("rnd_reset_edge", edge_cnt, exp_rst_q.pop_front());
                    chk("rnd_reset_shadow", int'(shadow_a), 0);
                end
            end
            if (nclk_a != pclk_a) begin
                ntog++; last_clk_a = edge_cnt;
                if (model_on) begin
                    if (exp_clk_q.size() == 0) chk("rnd_unexpected_clk", edge_cnt, -1);
                    else chk("rnd_clk_edge", edge_cnt, exp_clk_q.pop_front());
                end
            end
            if (ntog != 0) chk("one_toggle_per_edge", ntog, 1);
            if (bus_a.rsp_valid) begin
                rsp_cnt_a++; last_rsp_a = edge_cnt;
                last_d_a = bus_a.rsp_data; last_m_a = bus_a.rsp_mismatch;
                if (model_on) begin
                    if (exp_rsp_q.size() == 0) chk("rnd_unexpected_rsp", edge_cnt, -1);
                    else begin
                        r = exp_rsp_q.pop_front();
                        chk("rnd_rsp_edge", edge_cnt, r.e);
                        chk("rnd_rsp_data", int'(bus_a.rsp_data), int'(r.d));
                        chk("rnd_rsp_mismatch", int'(bus_a.rsp_mismatch), int'(r.m));
                    end
                end
            end
            if (reset_b != prst_b) last_rst_b = edge_cnt;
            if (nclk_b != pclk_b) last_clk_b = edge_cnt;
            pset_a = set_a; prst_a = reset_a; pclk_a = nclk_a; prst_b = reset_b; pclk_b = nclk_b;
        end
    end

    // Presents one command after 'gap' idle cycles; returns the offer and accept edge indices.
    task automatic send(input bit sel, input logic [1:0] op, input int gap,
                        output int offered, output int acc);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        if (sel) begin bus_b.cmd_valid = 1'b1; bus_b.cmd_op = op; end
        else     begin bus_a.cmd_valid = 1'b1; bus_a.cmd_op = op; end
        offered = edge_cnt + 1;
        n = 0;
        while (!(sel ? bus_b.cmd_ready : bus_a.cmd_ready) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            chk("accept_timeout", 1, 0);
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = edge_cnt;
        end
        bus_a.cmd_valid = 1'b0; bus_a.cmd_op = OP_NOP;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_op = OP_NOP;
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, int'({set_a, reset_a, nclk_a, shadow_a,
                        bus_a.rsp_valid, bus_a.rsp_data, bus_a.rsp_mismatch}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #3 chk("reset_ready", int'(bus_a.cmd_ready), 1);
    endtask

    typedef struct {
        logic [1:0] op; bit stuck; int gap; int exp_wait; int exp_fire;
        logic exp_shadow; logic exp_data; logic exp_mism;
    } vec_t;
    vec_t vecs[14];

    initial begin
        int off, acc, acc_r, fire, e_acc, gap, cnt0;
        int last_rst_m, last_clk_m, next_free;
        logic shadow_m, d;
        logic [1:0] op;
        rsp_t r;

        bus_a.cmd_valid = 1'b0; bus_a.cmd_op = OP_NOP;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_op = OP_NOP;

        //          op        stk gap wait fire sh  d   m
        vecs[0]  = '{OP_READ,  0, 0,  0,   0,   0,  0,  0};
        vecs[1]  = '{OP_SET,   0, 0,  0,   0,   1,  0,  0};
        vecs[2]  = '{OP_READ,  0, 0,  0,   0,   1,  1,  0};
        vecs[3]  = '{OP_RESET, 0, 0,  0,   0,   0,  0,  0};
        vecs[4]  = '{OP_SET,   0, 0,  0,   1,   1,  0,  0};
        vecs[5]  = '{OP_READ,  1, 0,  0,   0,   1,  0,  1};
        vecs[6]  = '{OP_READ,  0, 0,  0,   0,   1,  1,  0};
        vecs[7]  = '{OP_RESET, 0, 0,  0,   0,   0,  0,  0};
        vecs[8]  = '{OP_RESET, 0, 0,  0,   0,   0,  0,  0};
        vecs[9]  = '{OP_SET,   0, 0,  0,   1,   1,  0,  0};
        vecs[10] = '{OP_NOP,   0, 0,  0,   0,   1,  0,  0};
        vecs[11] = '{OP_SET,   0, 1,  0,   0,   1,  0,  0};
        vecs[12] = '{OP_RESET, 0, 2,  0,   0,   0,  0,  0};
        vecs[13] = '{OP_READ,  0, 0,  0,   0,   0,  0,  0};

        #1 rst_n = 1'b0;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            stuck_a = vecs[i].stuck;
            send(1'b0, vecs[i].op, vecs[i].gap, off, acc);
            chk($sformatf("v%0d_wait", i), acc - off, vecs[i].exp_wait);
            #2;
            if (vecs[i].op == OP_READ) begin
                chk($sformatf("v%0d_ready_busy", i), int'(bus_a.cmd_ready), 0);
                repeat (RW_A) @(posedge clk);
                #3;
                chk($sformatf("v%0d_clk_edge", i), last_clk_a - acc, 0);
                chk($sformatf("v%0d_rsp_edge", i), last_rsp_a - acc, RW_A);
                chk($sformatf("v%0d_rsp_data", i), int'(last_d_a), int'(vecs[i].exp_data));
                chk($sformatf("v%0d_rsp_mism", i), int'(last_m_a), int'(vecs[i].exp_mism));
            end else if (vecs[i].op != OP_NOP) begin
                if (vecs[i].exp_fire > 0) begin
                    chk($sformatf("v%0d_ready_guard", i), int'(bus_a.cmd_ready), 0);
                    repeat (vecs[i].exp_fire) @(posedge clk);
                    #3;
                end
                chk($sformatf("v%0d_fire_edge", i),
                    ((vecs[i].op == OP_SET) ? last_set_a : last_rst_a) - acc, vecs[i].exp_fire);
            end
            chk($sformatf("v%0d_shadow", i), int'(shadow_a), int'(vecs[i].exp_shadow));
        end

        // Clock-to-reset guard with long hold on DUT B.
        send(1'b1, OP_READ, 0, off, acc_r);
        send(1'b1, OP_RESET, 0, off, acc);
        chk("b_reset_accept", acc - acc_r, RW_B + 1);
        #2 chk("b_ready_guard", int'(bus_b.cmd_ready), 0);
        repeat (HOLD_B - RW_B - 1) @(posedge clk);
        #3;
        chk("b_clk_edge", last_clk_b - acc_r, 0);
        chk("b_reset_edge", last_rst_b - acc_r, HOLD_B);

        // Reset dropped in the middle of a read window.
        stuck_a = 1'b0;
        send(1'b0, OP_SET, 0, off, acc);
        send(1'b0, OP_READ, 0, off, acc);
        repeat (RW_A) @(posedge clk);
        #3 chk("abort_pre_data", int'(bus_a.rsp_data), 1);
        cnt0 = rsp_cnt_a;
        send(1'b0, OP_READ, 0, off, acc);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort_reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (RW_A + 2) @(posedge clk);
        #3;
        chk("abort_no_rsp", rsp_cnt_a - cnt0, 0);
        chk("abort_ready", int'(bus_a.cmd_ready), 1);
        chk("abort_clk_low", int'(nclk_a), 0);

        // Random commands against the edge-index model.
        do_reset();
        last_rst_m = -1000; last_clk_m = -1000; next_free = 0; shadow_m = 1'b0;
        model_on = 1'b1;
        for (int n = 0; n < 300; n++) begin
            op  = 2'($urandom_range(0, 3));
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (op == OP_READ) stuck_a = ($urandom_range(0, 4) == 0);
            send(1'b0, op, gap, off, acc);
            e_acc = (off > next_free) ? off : next_free;
            chk("rnd_accept_edge", acc, e_acc);
            case (op)
                OP_SET: begin
                    fire = (acc > last_rst_m + HOLD_A) ? acc : last_rst_m + HOLD_A;
                    exp_set_q.push_back(fire);
                    shadow_m  = 1'b1;
                    next_free = fire + 1;
                end
                OP_RESET: begin
                    fire = (acc > last_clk_m + HOLD_A) ? acc : last_clk_m + HOLD_A;
                    exp_rst_q.push_back(fire);
                    last_rst_m = fire;
                    shadow_m   = 1'b0;
                    next_free  = fire + 1;
                end
                OP_READ: begin
                    exp_clk_q.push_back(acc);
                    last_clk_m = acc;
                    d   = stuck_a ? 1'b0 : shadow_m;
                    r.e = acc + RW_A; r.d = d; r.m = d ^ shadow_m;
                    exp_rsp_q.push_back(r);
                    next_free = acc + RW_A + 1;
                end
                default: next_free = acc + 1;
            endcase
        end
        repeat (RW_A + HOLD_A + 6) @(posedge clk);
        #3;
        model_on = 1'b0;
        chk("rnd_drain", exp_set_q.size() + exp_rst_q.size() + exp_clk_q.size() + exp_rsp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
